// File: rtl/stn_wr_ctrl.sv
// stn_wr_ctrl: upstream write stage of the stn2tft data FIFO.
// Samples the S1D13700 STN panel bus, packs nibble pairs into bytes with a
// frame-relative address and feeds them to the FIFO RAM arbiter through a
// small pending-write queue that rides out read-priority stalls.
module stn_wr_ctrl #(
  parameter int FRAME_BYTES = 4800,
  parameter int BUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        stn_frame,
  input  logic        stn_line,
  input  logic        stn_shift,
  input  logic [3:0]  stn_data,
  output logic        fifo_wrreq,
  input  logic        fifo_wrack,
  output logic [12:0] fifo_waddr,
  output logic [7:0]  fifo_wdata,
  output logic        frame_start,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 13 + 8;
  localparam logic [12:0]      LAST_ADDR = 13'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    WAIT_FRM = 2'd0,
    HI       = 2'd1,
    LO       = 2'd2
  } state_t;

  // Frame-relative address step; wraps at the end of the frame.
  function automatic logic [12:0] addr_inc(input logic [12:0] a);
    if (a == LAST_ADDR) return 13'd0;
    return a + 13'd1;
  endfunction

  logic              frame_p0, frame_p1, frame_p2;
  logic              line_p0, line_p1, line_p2;
  logic              shift_p0, shift_p1, shift_p2;
  logic [3:0]        data_p0, data_p1;
  logic              frame_rise, line_rise, shift_fall;

  state_t            state;
  logic [12:0]       addr;
  logic [3:0]        hold;
  logic              take_hi, enq;
  logic [ENT_W-1:0]  enq_entry;

  logic [ENT_W-1:0]  mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              pop, push, drop;
  logic [ENT_W-1:0]  head_nxt;

  // Pad synchronisers: two flops per signal plus a third for edge detection.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      frame_p0 <= 1'b0; frame_p1 <= 1'b0; frame_p2 <= 1'b0;
      line_p0  <= 1'b0; line_p1  <= 1'b0; line_p2  <= 1'b0;
      shift_p0 <= 1'b0; shift_p1 <= 1'b0; shift_p2 <= 1'b0;
      data_p0  <= 4'd0; data_p1  <= 4'd0;
    end else begin
      frame_p0 <= stn_frame; frame_p1 <= frame_p0; frame_p2 <= frame_p1;
      line_p0  <= stn_line;  line_p1  <= line_p0;  line_p2  <= line_p1;
      shift_p0 <= stn_shift; shift_p1 <= shift_p0; shift_p2 <= shift_p1;
      data_p0  <= stn_data;  data_p1  <= data_p0;
    end
  end

  // ---- stage p1/p2 boundary: edge strobes, nibble data taken from data_p1 ----
  assign frame_rise = frame_p1 & ~frame_p2;
  assign line_rise  = line_p1  & ~line_p2;
  assign shift_fall = ~shift_p1 & shift_p2;

  // A shift edge only counts when neither a frame nor a line edge claims the cycle.
  assign take_hi   = (state == HI) & shift_fall & ~frame_rise & ~line_rise;
  assign enq       = (state == LO) & shift_fall & ~frame_rise & ~line_rise;
  assign enq_entry = {addr, hold, data_p1};

  // Nibble FSM: frame/line framing, address counter and frame_start pulse.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state       <= WAIT_FRM;
      addr        <= 13'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (frame_rise) begin
        state       <= HI;
        addr        <= 13'd0;
        frame_start <= 1'b1;
      end else begin
        case (state)
          WAIT_FRM: state <= WAIT_FRM;
          HI: begin
            if (line_rise)       state <= HI;
            else if (shift_fall) state <= LO;
          end
          LO: begin
            if (line_rise) begin
              state <= HI;
            end else if (shift_fall) begin
              state <= HI;
              addr  <= addr_inc(addr);
            end
          end
          default: state <= WAIT_FRM;
        endcase
      end
    end
  end

  // High nibble holding register; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (take_hi) hold <= data_p1;
  end

  // ---- stage p2/p3 boundary: pending-write queue and registered write port ----
  // Queue bookkeeping and the next head entry shown on the write port.
  always_comb begin
    pop        = fifo_wrreq & fifo_wrack;
    push       = enq & ((count < DEPTH_C) | pop);
    drop       = enq & ~push;
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    head_nxt   = mem[rd_ptr_nxt];
    if (push && (count_nxt == CNT_W'(1))) head_nxt = enq_entry;
  end

  // Queue storage; entries keep the address captured at enqueue time.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enq_entry;
  end

  // Queue pointers, write-port registers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_wrreq <= 1'b0;
      fifo_waddr <= 13'd0;
      fifo_wdata <= 8'd0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      fifo_wrreq <= (count_nxt != '0);
      if (count_nxt != '0) begin
        fifo_waddr <= head_nxt[ENT_W-1:8];
        fifo_wdata <= head_nxt[7:0];
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stn_wr_ctrl.sv
// Testbench for stn_wr_ctrl: vector table, hand-written corner sequences and
// a randomized bus stream checked against a byte-level reference model.
module tb_stn_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        stn_frame, stn_line, stn_shift;
  logic [3:0]  stn_data;
  logic        fifo_wrreq, fifo_wrack;
  logic [12:0] fifo_waddr;
  logic [7:0]  fifo_wdata;
  logic        frame_start, ovf, ovf_clr;

  stn_wr_ctrl #(.FRAME_BYTES(4800), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_x(rst_x),
    .stn_frame(stn_frame), .stn_line(stn_line), .stn_shift(stn_shift), .stn_data(stn_data),
    .fifo_wrreq(fifo_wrreq), .fifo_wrack(fifo_wrack),
    .fifo_waddr(fifo_waddr), .fifo_wdata(fifo_wdata),
    .frame_start(frame_start), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [12:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [12:0] a; logic [7:0] d; } exp_t;
  typedef struct {
    logic frm; logic ln; logic [3:0] hi; logic [3:0] lo; logic [12:0] ea; logic [7:0] ed;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   fs_cnt = 0;
  int   wr_mode = 0;
  wr_t  got_q[$];
  exp_t exp_q[$];

  // reference model state: byte framing at nibble granularity
  bit          m_in_frame = 0;
  bit          m_have_hi  = 0;
  logic [3:0]  m_hi = 4'd0;
  int          m_addr = 0;
  bit          m_drop_next = 0;

  bit          prev_stall = 0;
  logic [12:0] prev_a;
  logic [7:0]  prev_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write observer, frame_start counter and stall-hold check (sampled on negedge)
  always @(negedge clk) begin
    cyc++;
    if (!rst_x) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!(fifo_wrreq === 1'b1 && fifo_waddr === prev_a && fifo_wdata === prev_d)) begin
          bad++;
          $display("FAIL stall_hold: got req=%0b a=%0h d=%0h expected req=1 a=%0h d=%0h",
                   fifo_wrreq, fifo_waddr, fifo_wdata, prev_a, prev_d);
        end
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (fifo_wrreq === 1'b1 && fifo_wrack === 1'b1)
        got_q.push_back('{cyc: cyc, a: fifo_waddr, d: fifo_wdata});
      prev_stall = (fifo_wrreq === 1'b1) && (fifo_wrack === 1'b0);
      prev_a = fifo_waddr;
      prev_d = fifo_wdata;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (wr_mode == 1) fifo_wrack = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic model_nib(input logic [3:0] d);
    if (m_in_frame) begin
      if (!m_have_hi) begin
        m_hi = d;
        m_have_hi = 1;
      end else begin
        if (m_drop_next) m_drop_next = 0;
        else exp_q.push_back('{a: 13'(m_addr), d: {m_hi, d}});
        m_addr = (m_addr + 1) % 4800;
        m_have_hi = 0;
      end
    end
  endtask

  task automatic send_nib(input logic [3:0] d);
    stn_data = d; stn_shift = 1'b1;
    tick(2);
    stn_shift = 1'b0;
    tick(2);
    model_nib(d);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic pulse_frame();
    stn_frame = 1'b1; tick(2); stn_frame = 1'b0; tick(2);
    m_in_frame = 1; m_have_hi = 0; m_addr = 0;
  endtask

  task automatic pulse_line();
    stn_line = 1'b1; tick(2); stn_line = 1'b0; tick(2);
    if (m_in_frame) m_have_hi = 0;
  endtask

  task automatic wait_got(input int n, input int maxc, output bit ok);
    for (int i = 0; i < maxc && got_q.size() < n; i++) tick(1);
    ok = (got_q.size() >= n);
  endtask

  task automatic expect_write(input string nm, input logic [12:0] a, input logic [7:0] d);
    bit ok; wr_t g; exp_t e;
    wait_got(1, 40, ok);
    chk({nm, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      g = got_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({nm, "_addr"}, 32'(g.a), 32'(a));
      chk({nm, "_data"}, 32'(g.d), 32'(d));
    end
  endtask

  task automatic check_model(input string nm);
    bit ok; wr_t g; exp_t e; int n;
    n = exp_q.size();
    wait_got(n, 100, ok);
    tick(8);
    chk({nm, "_count"}, 32'(got_q.size()), 32'(n));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({nm, "_addr"}, 32'(g.a), 32'(e.a));
      chk({nm, "_data"}, 32'(g.d), 32'(e.d));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle(input string nm);
    tick(10);
    chk(nm, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec[7];
    wr_t  g;
    int   fs0;
    bit   ok;

    vec[0] = '{frm: 1, ln: 0, hi: 4'h1, lo: 4'h2, ea: 13'd0, ed: 8'h12};
    vec[1] = '{frm: 0, ln: 0, hi: 4'h3, lo: 4'h4, ea: 13'd1, ed: 8'h34};
    vec[2] = '{frm: 0, ln: 0, hi: 4'hA, lo: 4'hF, ea: 13'd2, ed: 8'hAF};
    vec[3] = '{frm: 1, ln: 0, hi: 4'h0, lo: 4'h0, ea: 13'd0, ed: 8'h00};
    vec[4] = '{frm: 0, ln: 0, hi: 4'hF, lo: 4'hF, ea: 13'd1, ed: 8'hFF};
    vec[5] = '{frm: 0, ln: 1, hi: 4'h5, lo: 4'hA, ea: 13'd2, ed: 8'h5A};
    vec[6] = '{frm: 1, ln: 0, hi: 4'h9, lo: 4'h6, ea: 13'd0, ed: 8'h96};

    rst_x = 1'b0; stn_frame = 1'b0; stn_line = 1'b0; stn_shift = 1'b0; stn_data = 4'd0;
    fifo_wrack = 1'b1; ovf_clr = 1'b0;
    tick(4);
    chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("rst_waddr", 32'(fifo_waddr), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_x = 1'b1;
    tick(4);

    // vector table (includes the basic 1,2,3,4 frame case)
    for (int i = 0; i < 7; i++) begin
      fs0 = fs_cnt;
      if (vec[i].frm) pulse_frame();
      if (vec[i].ln) pulse_line();
      send_nib(vec[i].hi);
      send_nib(vec[i].lo);
      expect_write($sformatf("vec%0d", i), vec[i].ea, vec[i].ed);
      if (vec[i].frm) chk($sformatf("vec%0d_fstart", i), 32'(fs_cnt - fs0), 32'd1);
    end
    check_idle("vec_extra");

    // leftover nibble before a line pulse is discarded
    pulse_frame();
    send_nib(4'hA); send_nib(4'hB); send_nib(4'hC);
    pulse_line();
    send_nib(4'hD); send_nib(4'hE);
    expect_write("line_b0", 13'd0, 8'hAB);
    expect_write("line_b1", 13'd1, 8'hDE);
    check_idle("line_extra");

    // long stall then back-to-back drain
    pulse_frame();
    fifo_wrack = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick(6);
    chk("stall_req", 32'(fifo_wrreq), 32'd1);
    chk("stall_head_a", 32'(fifo_waddr), 32'd0);
    chk("stall_head_d", 32'(fifo_wdata), 32'h11);
    tick(20);
    chk("stall_nowrite", 32'(got_q.size()), 32'd0);
    fifo_wrack = 1'b1;
    wait_got(3, 20, ok);
    chk("drain_seen", 32'(ok), 32'd1);
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        g = got_q[k];
        chk($sformatf("drain%0d_a", k), 32'(g.a), 32'(k));
        chk($sformatf("drain%0d_d", k), 32'(g.d), 32'(8'h11 * (k + 1)));
        if (k > 0) chk($sformatf("drain%0d_cyc", k), 32'(g.cyc - got_q[k-1].cyc), 32'd1);
      end
    end
    got_q.delete(); exp_q.delete();
    check_idle("drain_extra");

    // overflow: fifth byte dropped but still consumes an address
    pulse_frame();
    fifo_wrack = 1'b0;
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    chk("ovf_before", 32'(ovf), 32'd0);
    m_drop_next = 1;
    send_byte(8'hC4);
    tick(4);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head_a", 32'(fifo_waddr), 32'd0);
    fifo_wrack = 1'b1;
    check_model("ovf_kept");
    send_byte(8'h5A);
    expect_write("ovf_next", 13'd5, 8'h5A);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // randomized bus stream with random write acknowledge
    pulse_frame();
    wr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 86)      send_nib(4'($urandom_range(0, 15)));
      else if (r < 95) pulse_line();
      else             pulse_frame();
    end
    wr_mode = 0;
    fifo_wrack = 1'b1;
    check_model("rand");
    chk("rand_ovf", 32'(ovf), 32'd0);

    // full frame: wrap after FRAME_BYTES-1, then mid-frame restart
    pulse_frame();
    for (int i = 0; i < 4799; i++) send_byte(8'(i * 7 + 3));
    check_model("frame_stream");
    send_byte(8'hC3);
    expect_write("frame_last", 13'h12BF, 8'hC3);
    send_byte(8'h3C);
    expect_write("frame_wrap", 13'd0, 8'h3C);
    send_byte(8'h01);
    expect_write("frame_mid", 13'd1, 8'h01);
    pulse_frame();
    send_byte(8'h02);
    expect_write("frame_restart", 13'd0, 8'h02);

    // asynchronous reset with a non-empty queue
    pulse_frame();
    fifo_wrack = 1'b0;
    send_byte(8'hE1); send_byte(8'hE2);
    tick(4);
    chk("prerst_req", 32'(fifo_wrreq), 32'd1);
    @(posedge clk); #3;
    rst_x = 1'b0;
    #1;
    chk("rst_async_req", 32'(fifo_wrreq), 32'd0);
    chk("rst_async_a", 32'(fifo_waddr), 32'd0);
    tick(3);
    rst_x = 1'b1;
    m_in_frame = 0; m_have_hi = 0; m_addr = 0;
    exp_q.delete();
    chk("rst_nowrite", 32'(got_q.size()), 32'd0);
    got_q.delete();
    fifo_wrack = 1'b1;
    send_byte(8'h77); send_byte(8'h78);
    tick(10);
    chk("prefrm_nowrite", 32'(got_q.size()), 32'd0);
    chk("prefrm_req", 32'(fifo_wrreq), 32'd0);
    got_q.delete(); exp_q.delete();
    pulse_frame();
    send_byte(8'h88);
    expect_write("postrst", 13'd0, 8'h88);
    check_idle("postrst_extra");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
